// File: rtl/usr_seq_if.sv
// Command/data bus for usr_seq: the command handshake, the parallel load value
// and the status outputs (q, busy, done).
interface usr_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    // The block itself.
    modport slave (
        input  cmd_valid, cmd_op, cmd_count, load_data,
        output cmd_ready, q, busy, done
    );

    // Whoever issues commands.
    modport master (
        output cmd_valid, cmd_op, cmd_count, load_data,
        input  cmd_ready, q, busy, done
    );
endinterface

// File: rtl/usr_seq.sv
// usr_seq: universal shift register with a command handshake and a counted
// shift/rotate sequencer. One accepted command performs a clear, a parallel
// load, a nop, or 0..2^CNT_W-1 single-bit shift/rotate steps (one per clock).
// Optional feature macro: USR_SEQ_ABORT_EN adds the abort input and the
// aborted output, which cut a running step sequence short.
module usr_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    usr_seq_if.slave   bus,
    input  logic       sin_l,
    input  logic       sin_r,
    output logic       sout_l,
    output logic       sout_r
`ifdef USR_SEQ_ABORT_EN
    ,
    input  logic       abort,
    output logic       aborted
`endif
);

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SLL  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e           r_state, w_state_next;
    op_e              r_op, w_op_next;
    logic [CNT_W-1:0] r_rem, w_rem_next;
    logic [WIDTH-1:0] r_q, w_q_next;
    logic             r_done, w_done_next;
    op_e              w_cmd_op;
`ifdef USR_SEQ_ABORT_EN
    logic             r_aborted, w_aborted_next;
`endif

    // One single-bit step of the latched shift/rotate operation.
    function automatic logic [WIDTH-1:0] step(input op_e op, input logic [WIDTH-1:0] v,
                                              input logic sl, input logic sr);
        case (op)
            OP_SRL:  step = {sl, v[WIDTH-1:1]};
            OP_SLL:  step = {v[WIDTH-2:0], sr};
            OP_ROR:  step = {v[0], v[WIDTH-1:1]};
            OP_ROL:  step = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_SRA:  step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step = v;
        endcase
    endfunction

    assign w_cmd_op      = op_e'(bus.cmd_op);
    assign bus.cmd_ready = (r_state == S_IDLE) & ~reset;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = r_done;
    assign bus.q         = r_q;
    assign sout_l        = r_q[WIDTH-1];
    assign sout_r        = r_q[0];
`ifdef USR_SEQ_ABORT_EN
    assign aborted       = r_aborted;
`endif

    // Next-state, next-register and done-pulse decode for the sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_state_next = r_state;
        w_op_next    = r_op;
        w_rem_next   = r_rem;
        w_q_next     = r_q;
        w_done_next  = 1'b0;
`ifdef USR_SEQ_ABORT_EN
        w_aborted_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (w_cmd_op)
                        OP_CLR: begin
                            w_q_next    = '0;
                            w_done_next = 1'b1;
                        end
                        OP_LOAD: begin
                            w_q_next    = bus.load_data;
                            w_done_next = 1'b1;
                        end
                        OP_NOP: w_done_next = 1'b1;
                        default: begin
                            // Zero-step shift completes immediately, like a nop.
                            if (bus.cmd_count == '0) begin
                                w_done_next = 1'b1;
                            end else begin
                                w_op_next    = w_cmd_op;
                                w_rem_next   = bus.cmd_count;
                                w_state_next = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
`ifdef USR_SEQ_ABORT_EN
                if (abort) begin
                    w_rem_next     = '0;
                    w_state_next   = S_IDLE;
                    w_done_next    = 1'b1;
                    w_aborted_next = 1'b1;
                end else
`endif
                begin
                    w_q_next   = step(r_op, r_q, sin_l, sin_r);
                    w_rem_next = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset overrides any command.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_rem   <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_done  <= w_done_next;
`ifdef USR_SEQ_ABORT_EN
            r_aborted <= w_aborted_next;
`endif
        end
    end

endmodule

// File: tb/tb_usr_seq.sv
// Self-checking bench for usr_seq (WIDTH=8): directed cases plus randomized
// commands checked against an arithmetic reference model of the register.
// Define USR_SEQ_ABORT_EN to include the abort scenario.
module tb_usr_seq;
    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic reset;
    logic sin_l, sin_r, sout_l, sout_r;
`ifdef USR_SEQ_ABORT_EN
    logic abort, aborted;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned m_q = 0;   // reference model of the register contents

    usr_seq_if #(.WIDTH(W), .CNT_W(C)) bus ();

    usr_seq #(.WIDTH(W), .CNT_W(C)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .sout_l (sout_l),
        .sout_r (sout_r)
`ifdef USR_SEQ_ABORT_EN
        ,
        .abort  (abort),
        .aborted(aborted)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference step written from the operation definitions in plain arithmetic.
    function automatic int unsigned model_step(input int op, input int unsigned v,
                                               input int unsigned sl, input int unsigned sr);
        int unsigned msb_w = 1 << (W - 1);
        int unsigned mask  = (1 << W) - 1;
        case (op)
            1: return (v / 2) + sl * msb_w;
            2: return ((v * 2) + sr) & mask;
            4: return (v / 2) + (v % 2) * msb_w;
            5: return ((v * 2) & mask) + (v / msb_w);
            6: return (v / 2) + (v & msb_w);
            default: return v;
        endcase
    endfunction

    // Issues one command at the current falling edge and follows it to done.
    task automatic run_cmd(input int op, input int n, input int unsigned data,
                           input bit rand_sin, input bit hold);
        bit stepping = !(op == 0 || op == 3 || op == 7) && (n != 0);
        bit keep = hold && stepping;
        check("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_count = C'(n);
        bus.load_data = W'(data);
        @(negedge clk);
        if (!keep) bus.cmd_valid = 1'b0;
        if (op == 0) m_q = 0;
        else if (op == 3) m_q = data & 8'hFF;
        if (stepping) begin
            for (int i = 0; i < n; i++) begin
                check("run_busy", bus.busy, 1);
                check("run_done", bus.done, 0);
                check("run_ready", bus.cmd_ready, 0);
                check("run_q", bus.q, m_q);
                if (rand_sin) begin
                    sin_l = 1'($urandom);
                    sin_r = 1'($urandom);
                end
                m_q = model_step(op, m_q, sin_l, sin_r);
                @(negedge clk);
            end
        end
        bus.cmd_valid = 1'b0;
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_q", bus.q, m_q);
        check("sout_l", sout_l, (m_q >> (W - 1)) & 1);
        check("sout_r", sout_r, m_q & 1);
`ifdef USR_SEQ_ABORT_EN
        check("aborted_clear", aborted, 0);
`endif
        if (keep) begin
            @(negedge clk);
            check("no_reaccept_busy", bus.busy, 0);
            check("no_reaccept_done", bus.done, 0);
            check("no_reaccept_q", bus.q, m_q);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_count = '0;
        bus.load_data = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;
`ifdef USR_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_q", bus.q, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready_low", bus.cmd_ready, 0);
`ifdef USR_SEQ_ABORT_EN
        check("rst_aborted", aborted, 0);
`endif
        reset = 1'b0;
        #1;
        check("rst_ready_high", bus.cmd_ready, 1);
        @(negedge clk);

        // Parallel load.
        run_cmd(3, 0, 8'hB4, 0, 0);
        check("load_B4", bus.q, 8'hB4);

        // Shift right logical by 3 with sin_l=1, back-to-back with the load.
        sin_l = 1'b1;
        sin_r = 1'b0;
        run_cmd(1, 3, 0, 0, 0);
        check("srl3_F6", bus.q, 8'hF6);

        // Rotate left by 9 wraps to a single rotate; cmd_valid held during RUN.
        run_cmd(3, 0, 8'h81, 0, 0);
        run_cmd(5, 9, 0, 0, 1);
        check("rol9_03", bus.q, 8'h03);

        // Arithmetic shift right by 2.
        run_cmd(3, 0, 8'h90, 0, 0);
        run_cmd(6, 2, 0, 0, 0);
        check("sra2_E4", bus.q, 8'hE4);

        // Zero-step shift leaves q untouched.
        run_cmd(3, 0, 8'h5A, 0, 0);
        run_cmd(2, 0, 0, 0, 0);
        check("sll0_5A", bus.q, 8'h5A);

        // Clear and nop.
        run_cmd(7, 5, 0, 0, 0);
        check("nop_5A", bus.q, 8'h5A);
        run_cmd(0, 3, 0, 0, 0);
        check("clr_00", bus.q, 0);

        // Randomized commands with live serial inputs.
        for (int k = 0; k < 40; k++) begin
            run_cmd(int'($urandom_range(7, 0)), int'($urandom_range(15, 0)),
                    $urandom_range(255, 0), 1, 1'($urandom));
        end

        // Reset in the middle of a rotate, with cmd_valid held.
        run_cmd(3, 0, 8'h01, 0, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b100;
        bus.cmd_count = C'(8);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_run_busy", bus.busy, 1);
            check("rst_run_ready", bus.cmd_ready, 0);
            m_q = model_step(4, m_q, sin_l, sin_r);
            @(negedge clk);
        end
        check("rst_run_q20", bus.q, 8'h20);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_q", bus.q, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        m_q = 0;
        #1;
        check("midrst_ready", bus.cmd_ready, 1);
        @(negedge clk);
        check("midrst_no_done", bus.done, 0);
        check("midrst_q_hold", bus.q, 0);

`ifdef USR_SEQ_ABORT_EN
        // Abort after two steps of a 6-step right shift.
        run_cmd(3, 0, 8'hFF, 0, 0);
        sin_l = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b001;
        bus.cmd_count = C'(6);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("abort_run_busy", bus.busy, 1);
            @(negedge clk);
        end
        check("abort_pre_q", bus.q, 8'h3F);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_q_hold", bus.q, 8'h3F);
        check("abort_done", bus.done, 1);
        check("abort_flag", aborted, 1);
        check("abort_busy", bus.busy, 0);
        m_q = 8'h3F;
        run_cmd(3, 0, 8'h42, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
